multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multicycle MIPS control FSM. Sequences the shared datapath: memory, IR, regfile, ALU, PC.
//  Also owns the immediate sign-/zero-extend select that feeds ALU operand B.
//  Sits between the instruction register (op/funct) and the datapath mux and enable strobes.
//  Memory accesses use a ready handshake with a timeout.
// PARAMETERS
//  TIMEOUT  16  max cycles to wait for mem_ready in FETCH/MEMRD/MEMWR before ERROR (>=2)
//  CNT_W    5   width of the wait counter; must hold TIMEOUT
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  synchronous, active-high
//  op           in   6  IR[31:26], stable from DECODE onward
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes the current read/write this cycle
//  pc_write     out  1  PC load enable (includes branch-taken)
//  iord         out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  IR load enable
//  reg_dst      out  1  0 = rt, 1 = rd
//  mem_to_reg   out  1  0 = ALUOut, 1 = MDR
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  0 = PC, 1 = A
//  alu_src_b    out  2  00 = B, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2
//  alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  pc_src       out  2  00 = ALU, 01 = ALUOut, 10 = jump target
//  ext_zero     out  1  0 = sign-extend imm16 to 32, 1 = zero-extend
//  illegal      out  1  sticky; high in ERROR
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  Reset: state <= FETCH and wait_cnt <= 0; while reset is high, all outputs are forced to 0.
//  Outputs are Moore, decoded from state. Only exception: pc_write in BEQEX = zero.
//  States and encodings:
//   FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7,
//   BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, ERROR 12; unused codes go to ERROR.
//  FETCH:
//   Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
//   ir_write and pc_write assert only in the cycle mem_ready=1; then -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, add, ext_zero=0 (precomputes branch target). Next state by op:
//   100011 lw / 101011 sw -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 addi -> IMMEX;
//   000010 -> JEX; anything else -> ERROR.
//   R-type funct must be 100000/100010/100100/100101/101010, otherwise -> ERROR.
//  MEMADR: alu_src_a=1, alu_src_b=10, add, ext_zero=0; -> MEMRD if lw, MEMWR if sw.
//  MEMRD:  iord=1, mem_read=1; -> MEMWB on mem_ready.
//  MEMWB:  reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
//  MEMWR:  iord=1, mem_write=1; -> FETCH on mem_ready.
//  RTYPEEX: alu_src_a=1, alu_src_b=00, alu_control from funct; -> RTYPEWB.
//  RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
//  BEQEX: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_write=zero; -> FETCH.
//  IMMEX: alu_src_a=1, alu_src_b=10, add, ext_zero=0; -> IMMWB.
//  IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
//  JEX:   pc_src=10, pc_write=1; -> FETCH.
//  ERROR: illegal=1, all strobes 0; stays until reset.
//  Wait counter (covers FETCH, MEMRD, MEMWR):
//   Cleared on entry to each of these states; increments each cycle mem_ready=0.
//   If mem_ready=0 when wait_cnt==TIMEOUT-1 -> ERROR, and no strobe fires that cycle.
//   mem_ready=1 in the same cycle as the limit: completion wins.
//  Reset mid-instruction: aborts the access; the next cycle is FETCH with wait_cnt=0.
//  mem_ready outside FETCH/MEMRD/MEMWR is ignored.
// CONFIGURATION
//  `define LOGIC_IMM_EN adds andi 001100 and ori 001101:
//   DECODE -> IMMEX; IMMEX drives ext_zero=1 and alu_control 000 (andi) or 001 (ori); IMMWB as addi.
//  Without LOGIC_IMM_EN: those opcodes -> ERROR; ext_zero is constant 0.
// TESTING
//  lw: op=100011, mem_ready=1 every cycle -> states 0,1,2,3,4,0; reg_write only in MEMWB; 5 cycles.
//  beq: op=000100 with zero=1 -> pc_write=1, pc_src=01 in BEQEX; with zero=0 -> pc_write=0.
//  R-type slt: op=0, funct=101010 -> RTYPEEX alu_control=111, then RTYPEWB reg_dst=1, reg_write=1.
//  FETCH stall: mem_ready low 3 cycles, then high -> ir_write exactly once, in the 4th FETCH cycle.
//  Timeout: mem_ready held 0 in MEMWR for 16 cycles -> illegal=1 on cycle 17.
//   illegal stays high until reset; after reset, state=0 and illegal=0.
//  Bad op=111111 -> ERROR after DECODE.
//   With LOGIC_IMM_EN, ori imm=16'h8000 -> ext_zero=1 and alu_control=001 in IMMEX.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM with timed memory handshake and imm-extend select.
// Optional andi/ori support is enabled with `define LOGIC_IMM_EN.
module multicycle_ctrl_fsm #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] pc_src,
   output logic       ext_zero,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_IMMEX   = 4'd9,
      S_IMMWB   = 4'd10,
      S_JEX     = 4'd11,
      S_ERROR   = 4'd12
   } state_e;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             r_ok, imm_ok, imm_ext, is_wait, tmo;
   logic [2:0]       r_alu, imm_alu;

   always_comb begin
      r_ok  = 1'b1;
      r_alu = 3'b010;
      case (funct)
         6'b100000: r_alu = 3'b010;
         6'b100010: r_alu = 3'b110;
         6'b100100: r_alu = 3'b000;
         6'b100101: r_alu = 3'b001;
         6'b101010: r_alu = 3'b111;
         default: begin
            r_ok  = 1'b0;
            r_alu = 3'b000;
         end
      endcase
   end

   // addi always; andi/ori zero-extend and use logic ops
   always_comb begin
      imm_ok  = (op == OP_ADDI);
      imm_alu = 3'b010;
      imm_ext = 1'b0;
`ifdef LOGIC_IMM_EN
      if (op == 6'b001100) begin
         imm_ok  = 1'b1;
         imm_alu = 3'b000;
         imm_ext = 1'b1;
      end else if (op == 6'b001101) begin
         imm_ok  = 1'b1;
         imm_alu = 3'b001;
         imm_ext = 1'b1;
      end
`endif
   end

   assign is_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                    (state_q == S_MEMWR);
   assign tmo     = (wait_q == LIMIT) && !mem_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:
            if (mem_ready)  state_d = S_DECODE;
            else if (tmo)   state_d = S_ERROR;
         S_DECODE:
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:   state_d = r_ok ? S_RTYPEEX : S_ERROR;
               OP_BEQ: state_d = S_BEQEX;
               OP_J:   state_d = S_JEX;
               default: state_d = imm_ok ? S_IMMEX : S_ERROR;
            endcase
         S_MEMADR:
            if (op == OP_LW)      state_d = S_MEMRD;
            else if (op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_ERROR;
         S_MEMRD:
            if (mem_ready)  state_d = S_MEMWB;
            else if (tmo)   state_d = S_ERROR;
         S_MEMWR:
            if (mem_ready)  state_d = S_FETCH;
            else if (tmo)   state_d = S_ERROR;
         S_MEMWB:   state_d = S_FETCH;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_RTYPEWB: state_d = S_FETCH;
         S_BEQEX:   state_d = S_FETCH;
         S_IMMEX:   state_d = S_IMMWB;
         S_IMMWB:   state_d = S_FETCH;
         S_JEX:     state_d = S_FETCH;
         S_ERROR:   state_d = S_ERROR;
         default:   state_d = S_ERROR;
      endcase
      // only a stalled wait state keeps counting; any entry clears
      wait_d = '0;
      if (is_wait && state_d == state_q) wait_d = wait_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      pc_write    = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      pc_src      = 2'b00;
      ext_zero    = 1'b0;
      illegal     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_read    = 1'b1;
            alu_src_b   = 2'b01;
            alu_control = 3'b010;
            ir_write    = mem_ready;
            pc_write    = mem_ready;
         end
         S_DECODE: begin
            alu_src_b   = 2'b11;
            alu_control = 3'b010;
         end
         S_MEMADR: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = 3'b010;
         end
         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_RTYPEEX: begin
            alu_src_a   = 1'b1;
            alu_control = r_alu;
         end
         S_RTYPEWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BEQEX: begin
            alu_src_a   = 1'b1;
            alu_control = 3'b110;
            pc_src      = 2'b01;
            pc_write    = zero;
         end
         S_IMMEX: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = imm_alu;
            ext_zero    = imm_ext;
         end
         S_IMMWB:  reg_write = 1'b1;
         S_JEX: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         S_ERROR:  illegal = 1'b1;
         default: ;
      endcase
      if (reset) begin
         pc_write    = 1'b0;
         iord        = 1'b0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         ir_write    = 1'b0;
         reg_dst     = 1'b0;
         mem_to_reg  = 1'b0;
         reg_write   = 1'b0;
         alu_src_a   = 1'b0;
         alu_src_b   = 2'b00;
         alu_control = 3'b000;
         pc_src      = 2'b00;
         ext_zero    = 1'b0;
         illegal     = 1'b0;
      end
   end

   assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: directed per-cycle expectations.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
      logic [1:0] srcb;
      logic [2:0] alu;
      logic [1:0] pcsrc;
      logic       ext, ill;
   } out_t;

   typedef struct {
      out_t  v;
      string tag;
   } exp_t;

   localparam logic [3:0] FE = 0, DE = 1, MA = 2, MR = 3, MB = 4, MW = 5;
   localparam logic [3:0] RX = 6, RB = 7, BQ = 8, IX = 9, IB = 10, JX = 11;
   localparam logic [3:0] ER = 12;
   localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, NUL = 3'b000;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = '0, funct = '0;
   logic       zero = 1'b0, mem_ready = 1'b0;
   logic       pc_write, iord, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic       ext_zero, illegal;
   logic [3:0] state;

   exp_t  expq[$];
   string tag = "init";
   int    n_chk = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct),
      .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .pc_src(pc_src),
      .ext_zero(ext_zero), .illegal(illegal), .state(state)
   );

   // hand-written per-state strobe table; alu/ext/irw set per step
   function automatic out_t tbl(input logic [3:0] s);
      out_t o;
      o = '0;
      o.st = s;
      case (s)
         FE: begin o.mrd = 1; o.srcb = 2'b01; end
         DE: o.srcb = 2'b11;
         MA: begin o.srca = 1; o.srcb = 2'b10; end
         MR: begin o.iord = 1; o.mrd = 1; end
         MB: begin o.rw = 1; o.m2r = 1; end
         MW: begin o.iord = 1; o.mwr = 1; end
         RX: o.srca = 1;
         RB: begin o.rw = 1; o.rdst = 1; end
         BQ: begin o.srca = 1; o.pcsrc = 2'b01; end
         IX: begin o.srca = 1; o.srcb = 2'b10; end
         IB: o.rw = 1;
         JX: begin o.pcsrc = 2'b10; o.pcw = 1; end
         ER: o.ill = 1;
         default: ;
      endcase
      return o;
   endfunction

   task automatic step(input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r,
                       input logic [3:0] est, input logic epcw,
                       input logic eirw, input logic [2:0] ealu,
                       input logic eext);
      exp_t e;
      @(posedge clk);
      #1;
      reset = 1'b0;
      op = o;
      funct = f;
      zero = z;
      mem_ready = r;
      e.v = tbl(est);
      e.v.pcw = e.v.pcw | epcw;
      e.v.irw = eirw;
      e.v.alu = ealu;
      e.v.ext = eext;
      e.tag = tag;
      expq.push_back(e);
   endtask

   task automatic rst_step();
      exp_t e;
      @(posedge clk);
      #1;
      reset = 1'b1;
      mem_ready = 1'b1;
      zero = 1'b1;
      e.v = '0;
      e.tag = {tag, "/reset"};
      expq.push_back(e);
   endtask

   task automatic fd(input logic [5:0] o, input logic [5:0] f);
      step(o, f, 0, 1, FE, 1, 1, ADD, 0);
      step(o, f, 0, 1, DE, 0, 0, ADD, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      out_t got;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         got = '{st: state, pcw: pc_write, iord: iord, mrd: mem_read,
                 mwr: mem_write, irw: ir_write, rdst: reg_dst,
                 m2r: mem_to_reg, rw: reg_write, srca: alu_src_a,
                 srcb: alu_src_b, alu: alu_control, pcsrc: pc_src,
                 ext: ext_zero, ill: illegal};
         n_chk++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)",
                     e.tag, got, e.v, $time);
         end
      end
   end

   initial begin
      tag = "reset";
      rst_step();
      rst_step();

      tag = "lw";
      fd(LW, 0);
      step(LW, 0, 0, 1, MA, 0, 0, ADD, 0);
      step(LW, 0, 0, 1, MR, 0, 0, NUL, 0);
      step(LW, 0, 0, 1, MB, 0, 0, NUL, 0);

      tag = "sw";
      fd(SW, 0);
      step(SW, 0, 0, 1, MA, 0, 0, ADD, 0);
      step(SW, 0, 0, 1, MW, 0, 0, NUL, 0);

      tag = "beq_taken";
      fd(BEQ, 0);
      step(BEQ, 0, 1, 1, BQ, 1, 0, SUB, 0);
      tag = "beq_not";
      fd(BEQ, 0);
      step(BEQ, 0, 0, 1, BQ, 0, 0, SUB, 0);

      tag = "slt";
      fd(RT, 6'b101010);
      step(RT, 6'b101010, 0, 1, RX, 0, 0, 3'b111, 0);
      step(RT, 6'b101010, 0, 1, RB, 0, 0, NUL, 0);
      tag = "or";
      fd(RT, 6'b100101);
      step(RT, 6'b100101, 0, 1, RX, 0, 0, 3'b001, 0);
      step(RT, 6'b100101, 0, 1, RB, 0, 0, NUL, 0);

      tag = "addi";
      fd(ADDI, 0);
      step(ADDI, 0, 0, 1, IX, 0, 0, ADD, 0);
      step(ADDI, 0, 0, 1, IB, 0, 0, NUL, 0);

      tag = "j";
      fd(J, 0);
      step(J, 0, 0, 1, JX, 1, 0, NUL, 0);

      tag = "fetch_stall";
      for (int i = 0; i < 3; i++) step(ADDI, 0, 0, 0, FE, 0, 0, ADD, 0);
      step(ADDI, 0, 0, 1, FE, 1, 1, ADD, 0);
      step(ADDI, 0, 0, 1, DE, 0, 0, ADD, 0);
      step(ADDI, 0, 0, 1, IX, 0, 0, ADD, 0);
      step(ADDI, 0, 0, 1, IB, 0, 0, NUL, 0);

      tag = "fetch_limit_ready";
      for (int i = 0; i < 15; i++) step(J, 0, 0, 0, FE, 0, 0, ADD, 0);
      step(J, 0, 0, 1, FE, 1, 1, ADD, 0);
      step(J, 0, 0, 1, DE, 0, 0, ADD, 0);
      step(J, 0, 0, 1, JX, 1, 0, NUL, 0);

      tag = "memrd_stall";
      fd(LW, 0);
      step(LW, 0, 0, 0, MA, 0, 0, ADD, 0);
      step(LW, 0, 0, 0, MR, 0, 0, NUL, 0);
      step(LW, 0, 0, 1, MR, 0, 0, NUL, 0);
      step(LW, 0, 0, 1, MB, 0, 0, NUL, 0);

      tag = "memwr_timeout";
      fd(SW, 0);
      step(SW, 0, 0, 0, MA, 0, 0, ADD, 0);
      for (int i = 0; i < 16; i++) step(SW, 0, 0, 0, MW, 0, 0, NUL, 0);
      step(SW, 0, 1, 1, ER, 0, 0, NUL, 0);
      step(SW, 0, 1, 1, ER, 0, 0, NUL, 0);
      step(J, 0, 1, 1, ER, 0, 0, NUL, 0);
      rst_step();
      tag = "after_reset";
      step(J, 0, 0, 0, FE, 0, 0, ADD, 0);

      tag = "bad_op";
      step(6'b111111, 0, 0, 1, FE, 1, 1, ADD, 0);
      step(6'b111111, 0, 0, 1, DE, 0, 0, ADD, 0);
      step(6'b111111, 0, 0, 1, ER, 0, 0, NUL, 0);
      rst_step();

      tag = "bad_funct";
      fd(RT, 6'b000000);
      step(RT, 0, 0, 1, ER, 0, 0, NUL, 0);
      rst_step();

`ifdef LOGIC_IMM_EN
      tag = "ori";
      fd(6'b001101, 0);
      step(6'b001101, 0, 0, 1, IX, 0, 0, 3'b001, 1);
      step(6'b001101, 0, 0, 1, IB, 0, 0, NUL, 0);
      tag = "andi";
      fd(6'b001100, 0);
      step(6'b001100, 0, 0, 1, IX, 0, 0, 3'b000, 1);
      step(6'b001100, 0, 0, 1, IB, 0, 0, NUL, 0);
`else
      tag = "andi_off";
      fd(6'b001100, 0);
      step(6'b001100, 0, 0, 1, ER, 0, 0, NUL, 0);
      rst_step();
      tag = "ori_off";
      fd(6'b001101, 0);
      step(6'b001101, 0, 0, 1, ER, 0, 0, NUL, 0);
      rst_step();
`endif

      tag = "reset_mid";
      fd(LW, 0);
      step(LW, 0, 0, 0, MA, 0, 0, ADD, 0);
      step(LW, 0, 0, 0, MR, 0, 0, NUL, 0);
      step(LW, 0, 0, 0, MR, 0, 0, NUL, 0);
      rst_step();
      step(LW, 0, 0, 0, FE, 0, 0, ADD, 0);
      step(LW, 0, 0, 1, FE, 1, 1, ADD, 0);
      step(LW, 0, 0, 1, DE, 0, 0, ADD, 0);

      repeat (3) @(posedge clk);
      n_chk++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d left, required 0", expq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
